// File: rtl/reg_bank_if.sv
// rtl/reg_bank_if.sv - register bank read/write/clear bus bundle
interface reg_bank_if #(
   parameter int DW = 16,
   parameter int AW = 2
);
   localparam int DEPTH = 2 ** AW;

   logic [AW-1:0]    r_add1;
   logic [AW-1:0]    r_add2;
   logic [AW-1:0]    rg_sel;
   logic [AW-1:0]    w_add;
   logic             w_flag;
   logic [DW-1:0]    w_data;
   logic             clr_req;
   logic [DW-1:0]    r_data1;
   logic [DW-1:0]    r_data2;
   logic [DW-1:0]    rgsel_data;
   logic [DEPTH-1:0] dirty;
   logic             busy;
   logic             clr_done;

   modport master (
      output r_add1, r_add2, rg_sel, w_add, w_flag, w_data, clr_req,
      input  r_data1, r_data2, rgsel_data, dirty, busy, clr_done
   );

   modport slave (
      input  r_add1, r_add2, rg_sel, w_add, w_flag, w_data, clr_req,
      output r_data1, r_data2, rgsel_data, dirty, busy, clr_done
   );
endinterface

// File: rtl/reg_bank.sv
// rtl/reg_bank.sv - parametrised register bank with bypass, dirty mask and clear engine
module reg_bank #(
   parameter int DW     = 16,
   parameter int AW     = 2,
   parameter int BYPASS = 1
) (
   input  logic       clk,
   input  logic       reset,
   reg_bank_if.slave  bus
);
   localparam int DEPTH = 2 ** AW;

   typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

   state_t           state_q, state_d;
   logic [AW-1:0]    ptr_q, ptr_d;
   logic [DW-1:0]    mem_q [DEPTH];
   logic [DW-1:0]    mem_d [DEPTH];
   logic [DEPTH-1:0] dirty_q, dirty_d;
   logic             busy;
   logic             wr_en;

   assign busy  = (state_q != IDLE);
   assign wr_en = bus.w_flag && !busy;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      mem_d   = mem_q;
      dirty_d = dirty_q;

      // Writes are only accepted in IDLE, so they never collide with the clear pointer.
      if (wr_en) begin
         mem_d[bus.w_add]   = bus.w_data;
         dirty_d[bus.w_add] = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (bus.clr_req) begin
               state_d = CLEAR;
               ptr_d   = '0;
            end
         end
         CLEAR: begin
            mem_d[ptr_q]   = '0;
            dirty_d[ptr_q] = 1'b0;
            ptr_d          = ptr_q + AW'(1);
            if (ptr_q == AW'(DEPTH - 1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         dirty_q <= '0;
         state_q <= IDLE;
         ptr_q   <= '0;
      end else begin
         mem_q   <= mem_d;
         dirty_q <= dirty_d;
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // The debug port always shows stored contents; only operand ports see forwarded data.
   assign bus.r_data1    = ((BYPASS != 0) && wr_en && (bus.w_add == bus.r_add1)) ?
                           bus.w_data : mem_q[bus.r_add1];
   assign bus.r_data2    = ((BYPASS != 0) && wr_en && (bus.w_add == bus.r_add2)) ?
                           bus.w_data : mem_q[bus.r_add2];
   assign bus.rgsel_data = mem_q[bus.rg_sel];
   assign bus.dirty      = dirty_q;
   assign bus.busy       = busy;
   assign bus.clr_done   = (state_q == DONE);
endmodule

// File: tb/tb_reg_bank.sv
// tb/tb_reg_bank.sv - directed table-driven bench for reg_bank
module tb_reg_bank;
   logic clk;
   logic reset;
   int   checks;
   int   failures;

   reg_bank_if #(.DW(16), .AW(2)) bus1 ();
   reg_bank_if #(.DW(16), .AW(2)) bus0 ();

   reg_bank #(.DW(16), .AW(2), .BYPASS(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
   reg_bank #(.DW(16), .AW(2), .BYPASS(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

   initial clk = 1'b0;
   always #10 clk = ~clk;

   typedef struct {
      logic        w_flag;
      logic [1:0]  w_add;
      logic [15:0] w_data;
      logic [1:0]  r1;
      logic [1:0]  r2;
      logic [1:0]  rg;
      logic [15:0] e_r1;
      logic [15:0] e_r2;
      logic [15:0] e_rg;
      logic [15:0] e_r1_nb;
      logic [3:0]  e_dirty;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic wf, input logic [1:0] wa, input logic [15:0] wd,
                         input logic [1:0] a1, input logic [1:0] a2, input logic [1:0] rs,
                         input logic cr);
      bus1.w_flag = wf;  bus0.w_flag = wf;
      bus1.w_add  = wa;  bus0.w_add  = wa;
      bus1.w_data = wd;  bus0.w_data = wd;
      bus1.r_add1 = a1;  bus0.r_add1 = a1;
      bus1.r_add2 = a2;  bus0.r_add2 = a2;
      bus1.rg_sel = rs;  bus0.rg_sel = rs;
      bus1.clr_req = cr; bus0.clr_req = cr;
   endtask

   task automatic fill(input logic [15:0] base);
      for (int a = 0; a < 4; a++) begin
         set_in(1'b1, 2'(a), base + 16'(a), 2'd0, 2'd0, 2'd0, 1'b0);
         @(negedge clk);
      end
      set_in(1'b0, 2'd0, 16'h0, 2'd0, 2'd0, 2'd0, 1'b0);
   endtask

   initial begin
      int busy_cnt;
      int done_cnt;
      int done_cyc;
      logic [15:0] exp_v;

      checks   = 0;
      failures = 0;
      vecs[0] = '{1'b1, 2'd2, 16'hBEEF, 2'd2, 2'd0, 2'd2, 16'hBEEF, 16'h0000, 16'h0000, 16'h0000, 4'b0000};
      vecs[1] = '{1'b0, 2'd0, 16'h0000, 2'd2, 2'd2, 2'd2, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF, 4'b0100};
      vecs[2] = '{1'b1, 2'd0, 16'h1111, 2'd0, 2'd2, 2'd0, 16'h1111, 16'hBEEF, 16'h0000, 16'h0000, 4'b0100};
      vecs[3] = '{1'b1, 2'd3, 16'h2222, 2'd0, 2'd3, 2'd3, 16'h1111, 16'h2222, 16'h0000, 16'h1111, 4'b0101};
      vecs[4] = '{1'b1, 2'd2, 16'h3333, 2'd3, 2'd2, 2'd2, 16'h2222, 16'h3333, 16'hBEEF, 16'h2222, 4'b1101};
      vecs[5] = '{1'b0, 2'd0, 16'h0000, 2'd1, 2'd2, 2'd1, 16'h0000, 16'h3333, 16'h0000, 16'h0000, 4'b1101};
      vecs[6] = '{1'b1, 2'd1, 16'h0004, 2'd1, 2'd1, 2'd2, 16'h0004, 16'h0004, 16'h3333, 16'h0000, 4'b1101};
      vecs[7] = '{1'b0, 2'd0, 16'h0000, 2'd1, 2'd0, 2'd3, 16'h0004, 16'h1111, 16'h2222, 16'h0004, 4'b1111};

      reset = 1'b1;
      set_in(1'b0, 2'd0, 16'h0, 2'd0, 2'd0, 2'd0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_dirty", 32'(bus1.dirty), 32'h0);
      check("rst_busy", 32'(bus1.busy), 32'h0);
      check("rst_clr_done", 32'(bus1.clr_done), 32'h0);
      check("rst_r_data1", 32'(bus1.r_data1), 32'h0);
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         set_in(vecs[i].w_flag, vecs[i].w_add, vecs[i].w_data,
                vecs[i].r1, vecs[i].r2, vecs[i].rg, 1'b0);
         #1;
         check($sformatf("vec%0d_r_data1", i), 32'(bus1.r_data1), 32'(vecs[i].e_r1));
         check($sformatf("vec%0d_r_data2", i), 32'(bus1.r_data2), 32'(vecs[i].e_r2));
         check($sformatf("vec%0d_rgsel", i), 32'(bus1.rgsel_data), 32'(vecs[i].e_rg));
         check($sformatf("vec%0d_dirty", i), 32'(bus1.dirty), 32'(vecs[i].e_dirty));
         check($sformatf("vec%0d_nobypass_r1", i), 32'(bus0.r_data1), 32'(vecs[i].e_r1_nb));
         @(negedge clk);
      end

      // Reset over populated entries, with a competing write that must lose.
      set_in(1'b1, 2'd0, 16'h5555, 2'd0, 2'd0, 2'd0, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      set_in(1'b0, 2'd0, 16'h0, 2'd0, 2'd3, 2'd0, 1'b0);
      for (int a = 0; a < 4; a++) begin
         bus1.rg_sel = 2'(a);
         #1;
         check($sformatf("rst2_entry%0d", a), 32'(bus1.rgsel_data), 32'h0);
      end
      check("rst2_r_data1", 32'(bus1.r_data1), 32'h0);
      check("rst2_r_data2", 32'(bus1.r_data2), 32'h0);
      check("rst2_dirty", 32'(bus1.dirty), 32'h0);
      check("rst2_busy", 32'(bus1.busy), 32'h0);
      @(negedge clk);

      // Sequenced clear with dropped write and ignored clr_req mid-clear.
      fill(16'h0001);
      set_in(1'b0, 2'd0, 16'h0, 2'd0, 2'd0, 2'd0, 1'b1);
      @(negedge clk);
      busy_cnt = 0;
      done_cnt = 0;
      done_cyc = 0;
      for (int cyc = 1; cyc <= 7; cyc++) begin
         if (cyc == 2 || cyc == 3)
            set_in(1'b1, 2'd1, 16'h1234, 2'd1, 2'd0, 2'd0, 1'b1);
         else
            set_in(1'b0, 2'd0, 16'h0, 2'd1, 2'd0, 2'd0, 1'b0);
         #1;
         if (bus1.busy) busy_cnt++;
         if (bus1.clr_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (cyc == 2) check("clr_no_bypass_r1", 32'(bus1.r_data1), 32'h2);
         if (cyc == 3) begin
            check("clr_drop_r1", 32'(bus1.r_data1), 32'h0);
            check("clr_dirty_mid", 32'(bus1.dirty), 32'b1100);
         end
         for (int a = 0; a < 4; a++) begin
            bus1.rg_sel = 2'(a);
            #1;
            exp_v = (a < cyc - 1) ? 16'h0 : 16'(a + 1);
            check($sformatf("clr_c%0d_entry%0d", cyc, a), 32'(bus1.rgsel_data), 32'(exp_v));
         end
         @(negedge clk);
      end
      check("clr_busy_cycles", 32'(busy_cnt), 32'd5);
      check("clr_done_count", 32'(done_cnt), 32'd1);
      check("clr_done_cycle", 32'(done_cyc), 32'd5);
      check("clr_dirty_after", 32'(bus1.dirty), 32'h0);

      // Reset during the second CLEAR cycle aborts the clear.
      fill(16'h0010);
      set_in(1'b0, 2'd0, 16'h0, 2'd0, 2'd0, 2'd0, 1'b1);
      @(negedge clk);
      set_in(1'b0, 2'd0, 16'h0, 2'd0, 2'd0, 2'd0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      done_cnt = 0;
      busy_cnt = 0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         #1;
         if (bus1.busy) busy_cnt++;
         if (bus1.clr_done) done_cnt++;
         @(negedge clk);
      end
      check("abort_busy", 32'(busy_cnt), 32'd0);
      check("abort_clr_done", 32'(done_cnt), 32'd0);
      check("abort_dirty", 32'(bus1.dirty), 32'h0);
      for (int a = 0; a < 4; a++) begin
         bus1.rg_sel = 2'(a);
         #1;
         check($sformatf("abort_entry%0d", a), 32'(bus1.rgsel_data), 32'h0);
      end
      @(negedge clk);

      // Write and clr_req in the same IDLE cycle: write lands, then gets cleared last.
      set_in(1'b1, 2'd3, 16'h00AA, 2'd0, 2'd0, 2'd3, 1'b1);
      @(negedge clk);
      set_in(1'b0, 2'd0, 16'h0, 2'd0, 2'd0, 2'd3, 1'b0);
      for (int cyc = 1; cyc <= 6; cyc++) begin
         #1;
         if (cyc == 1) check("wclr_dirty", 32'(bus1.dirty), 32'b1000);
         exp_v = (cyc < 5) ? 16'h00AA : 16'h0;
         check($sformatf("wclr_c%0d_entry3", cyc), 32'(bus1.rgsel_data), 32'(exp_v));
         if (cyc == 6) check("wclr_busy_end", 32'(bus1.busy), 32'h0);
         @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
